// File: rtl/multicycle_controller.sv
// Purpose: multicycle controller sequencing fetch/decode/execute/memory/writeback over one memory port.
// Latency: 3 cycles (branch) to 5 cycles (load) per instruction, plus memory wait states.
// Backpressure: mem_ready stalls FETCH/MEMRD/MEMWR; a hung bus raises bus_fault after TIMEOUT_CYCLES waits.
module multicycle_controller #(
  parameter int HAS_MEM_READY  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] cond,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_ctl,
  output logic       shift,
  output logic       carry,
  output logic       illegal,
  output logic       bus_fault
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      flags_q, flags_d;
  logic            cond_q, cond_d;
  logic            no_write_q, no_write_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic mem_rdy;
  logic cond_pass;
  logic timeout;
  logic pc_write_c, ir_write_c, mem_write_c, reg_write_c;
  logic cmd_legal, cmd_arith, cmd_cmp, cmd_mov;
  logic [2:0] cmd_ctl;
  logic flag_n, flag_z, flag_c, flag_v;

  assign mem_rdy = (HAS_MEM_READY != 0) ? mem_ready : 1'b1;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Evaluate the instruction condition field against the stored NZCV flags.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Decode the data-processing command field into ALU control and side attributes.
  always_comb begin
    cmd_legal = 1'b1;
    cmd_arith = 1'b0;
    cmd_cmp   = 1'b0;
    cmd_mov   = 1'b0;
    cmd_ctl   = ALU_ADD;
    case (funct[4:1])
      4'b0100: cmd_arith = 1'b1;
      4'b0010: begin cmd_ctl = ALU_SUB; cmd_arith = 1'b1; end
      4'b0000: cmd_ctl = ALU_AND;
      4'b1100: cmd_ctl = ALU_ORR;
      4'b1010: begin cmd_ctl = ALU_SUB; cmd_arith = 1'b1; cmd_cmp = 1'b1; end
      4'b1101: cmd_mov = 1'b1;
      default: cmd_legal = 1'b0;
    endcase
  end

  // Count consecutive wait cycles in memory-facing states; flag a timeout on the last allowed one.
  always_comb begin
    timeout    = 1'b0;
    wait_cnt_d = '0;
    if ((state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !mem_rdy) begin
      if (TIMEOUT_CYCLES > 0 && wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
    end
  end

  // Next-state, datapath controls and flag/condition updates for the current state.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    cond_d      = cond_q;
    no_write_d  = no_write_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_ctl     = ALU_ADD;
    shift       = 1'b0;
    illegal     = 1'b0;
    bus_fault   = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem_rdy;
        pc_write_c = mem_rdy;
        if (mem_rdy) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        cond_d    = cond_pass;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: begin illegal = 1'b1; state_d = FETCH; end
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        alu_ctl   = funct[3] ? ALU_ADD : ALU_SUB;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = MEMWB;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = cond_q;
        state_d     = FETCH;
      end
      MEMWR: begin
        adr_src     = 1'b1;
        mem_write_c = cond_q;
        if (mem_rdy) state_d = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
        if (!cmd_legal) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          alu_ctl    = cmd_ctl;
          shift      = cmd_mov;
          no_write_d = cmd_cmp;
          if (cond_q && funct[0]) begin
            flags_d[3:2] = alu_flags[3:2];
            if (cmd_arith) flags_d[1:0] = alu_flags[1:0];
          end
          state_d = ALUWB;
        end
      end
      ALUWB: begin
        if (rd != 4'd15) begin
          reg_write_c = cond_q & ~no_write_q;
        end else if (!no_write_q) begin
          pc_write_c = cond_q;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write_c = cond_q;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // A hung bus abandons the access with every strobe held low.
    if (timeout) begin
      bus_fault   = 1'b1;
      state_d     = FETCH;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
    end
  end

  // State, flags, latched condition and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      flags_q    <= 4'b0000;
      cond_q     <= 1'b0;
      no_write_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      cond_q     <= cond_d;
      no_write_q <= no_write_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Strobes are masked by reset so an access in flight is dropped immediately.
  assign pc_write  = pc_write_c  & ~reset;
  assign ir_write  = ir_write_c  & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign imm_src   = op;
  assign reg_src   = {op == 2'b01, op == 2'b10};
  assign carry     = flags_q[1];

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: directed self-checking bench for multicycle_controller against an instruction-level model.
// Latency: model expands each instruction into its expected per-cycle output trace.
// Backpressure: mem_ready pattern per instruction is part of each directed vector.
module tb_multicycle_controller;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond, rd, alu_flags;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src;
  logic [2:0] alu_ctl;
  logic       shift, carry, illegal, bus_fault;

  multicycle_controller #(.HAS_MEM_READY(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond(cond), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_write(pc_write),
    .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
    .alu_ctl(alu_ctl), .shift(shift), .carry(carry), .illegal(illegal),
    .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, memw, regw, ill, bf, adr, asa;
    logic [1:0] asb, rsrc;
    logic [2:0] ctl;
    logic       sh, cy;
  } ovec_t;

  ovec_t dut_v;
  assign dut_v = {pc_write, ir_write, mem_write, reg_write, illegal, bus_fault,
                  adr_src, alu_src_a, alu_src_b, result_src, alu_ctl, shift, carry};

  ovec_t exp_q[$];
  ovec_t msk_q[$];
  logic  mr_q[$];
  ovec_t e, k;
  logic [3:0] flags_m;
  int n_checks = 0;
  int n_fail = 0;
  int rw_cnt, pw_cnt, mw_cnt, bf_cnt, ill_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ARM condition codes: odd codes are the negation of the even code below them.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic new_cycle();
    e = '0;
    k = '0;
    k.pcw = 1; k.irw = 1; k.memw = 1; k.regw = 1; k.ill = 1; k.bf = 1; k.cy = 1;
    e.cy = flags_m[1];
  endtask

  task automatic push(input logic mr);
    exp_q.push_back(e);
    msk_q.push_back(k);
    mr_q.push_back(mr);
  endtask

  task automatic want_fetch_mux();
    e.adr = 0;     k.adr = 1;
    e.asa = 1;     k.asa = 1;
    e.asb = 2'b10; k.asb = '1;
    e.rsrc = 2'b10; k.rsrc = '1;
    e.ctl = 3'b000; k.ctl = '1;
  endtask

  task automatic run(input int limit, input string tag);
    ovec_t ee, kk;
    int n = 0;
    while (exp_q.size() > 0 && (limit == 0 || n < limit)) begin
      ee = exp_q.pop_front();
      kk = msk_q.pop_front();
      mem_ready = mr_q.pop_front();
      @(negedge clk);
      n_checks++;
      if ((dut_v & kk) !== (ee & kk)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs %h, expected %h (mask %h)", tag, n, dut_v & kk, ee & kk, kk);
      end
      check({tag, "/imm_reg_src"}, {28'd0, imm_src, reg_src}, {28'd0, op, op == 2'b01, op == 2'b10});
      rw_cnt  += int'(reg_write);
      pw_cnt  += int'(pc_write);
      mw_cnt  += int'(mem_write);
      bf_cnt  += int'(bus_fault);
      ill_cnt += int'(illegal);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Expand one instruction into its expected cycle trace, then drive and compare it.
  task automatic instr(input string tag, input logic [1:0] i_op, input logic [5:0] i_funct,
                       input logic [3:0] i_cond, input logic [3:0] i_rd, input logic [3:0] i_af,
                       input int fw, input int mw, input int limit);
    logic c, legal, arith, nw;
    logic [3:0] cmd;
    op = i_op; funct = i_funct; cond = i_cond; rd = i_rd; alu_flags = i_af;
    rw_cnt = 0; pw_cnt = 0; mw_cnt = 0; bf_cnt = 0; ill_cnt = 0;
    for (int i = 0; i < fw; i++) begin new_cycle(); want_fetch_mux(); push(1'b0); end
    new_cycle(); want_fetch_mux(); e.pcw = 1; e.irw = 1; push(1'b1);
    c = cond_holds(i_cond, flags_m);
    new_cycle(); e.asa = 1; k.asa = 1; e.asb = 2'b10; k.asb = '1;
    if (i_op == 2'b11) begin
      e.ill = 1; push(1'b1);
    end else begin
      push(1'b1);
      if (i_op == 2'b01) begin
        new_cycle(); e.asb = 2'b01; k.asb = '1; e.ctl = i_funct[3] ? 3'b000 : 3'b001; k.ctl = '1;
        push(1'b1);
        if (i_funct[0]) begin
          for (int i = 0; i < mw; i++) begin new_cycle(); e.adr = 1; k.adr = 1; push(1'b0); end
          new_cycle(); e.adr = 1; k.adr = 1; push(1'b1);
          new_cycle(); e.rsrc = 2'b01; k.rsrc = '1; e.regw = c; push(1'b1);
        end else if (mw >= TO) begin
          for (int i = 1; i <= TO; i++) begin
            new_cycle(); e.adr = 1; k.adr = 1;
            if (i < TO) e.memw = c; else e.bf = 1;
            push(1'b0);
          end
        end else begin
          for (int i = 0; i < mw; i++) begin
            new_cycle(); e.adr = 1; k.adr = 1; e.memw = c; push(1'b0);
          end
          new_cycle(); e.adr = 1; k.adr = 1; e.memw = c; push(1'b1);
        end
      end else if (i_op == 2'b10) begin
        new_cycle(); e.asa = 0; k.asa = 1; e.asb = 2'b01; k.asb = '1;
        e.ctl = 3'b000; k.ctl = '1; e.rsrc = 2'b10; k.rsrc = '1; e.pcw = c;
        push(1'b1);
      end else begin
        cmd   = i_funct[4:1];
        legal = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};
        arith = cmd inside {4'b0100, 4'b0010, 4'b1010};
        nw    = (cmd == 4'b1010);
        new_cycle();
        if (!legal) begin
          e.ill = 1; push(1'b1);
        end else begin
          e.asa = 0; k.asa = 1;
          e.asb = i_funct[5] ? 2'b01 : 2'b00; k.asb = '1;
          e.sh = (cmd == 4'b1101); k.sh = 1;
          if (cmd != 4'b1101) begin
            k.ctl = '1;
            case (cmd)
              4'b0100: e.ctl = 3'b000;
              4'b0010, 4'b1010: e.ctl = 3'b001;
              4'b0000: e.ctl = 3'b010;
              default: e.ctl = 3'b011;
            endcase
          end
          push(1'b1);
          if (c && i_funct[0]) begin
            flags_m[3:2] = i_af[3:2];
            if (arith) flags_m[1:0] = i_af[1:0];
          end
          new_cycle(); e.rsrc = 2'b00; k.rsrc = '1;
          if (i_rd != 4'd15) e.regw = c & ~nw; else e.pcw = c & ~nw;
          push(1'b1);
        end
      end
    end
    run(limit, tag);
  endtask

  initial begin
    reset = 1; op = 0; funct = 0; cond = 0; rd = 0; alu_flags = 0; mem_ready = 0;
    flags_m = 4'b0000;
    @(negedge clk);
    check("rst_strobes", {26'd0, pc_write, ir_write, mem_write, reg_write, illegal, bus_fault}, 32'd0);
    check("rst_mux", {23'd0, adr_src, alu_src_a, alu_src_b, result_src, alu_ctl}, 32'b011010000);
    check("rst_carry", {31'd0, carry}, 32'd0);
    mem_ready = 1;
    #1;
    check("rst_gates_fetch_strobes", {30'd0, pc_write, ir_write}, 32'd0);
    @(posedge clk); #1;
    reset = 0; mem_ready = 0;

    instr("adds", 2'b00, 6'b001001, 4'he, 4'd1, 4'b0110, 0, 0, 0);
    check("adds_carry", {31'd0, carry}, 32'd1);
    check("adds_regwrite", rw_cnt, 1);
    instr("ldr", 2'b01, 6'b011001, 4'he, 4'd2, 4'b0000, 1, 3, 0);
    check("ldr_regwrite_once", rw_cnt, 1);
    instr("beq_taken", 2'b10, 6'b100000, 4'h0, 4'd0, 4'b0000, 0, 0, 0);
    check("beq_taken_pcw", pw_cnt, 2);
    instr("cmp_r15", 2'b00, 6'b010101, 4'he, 4'd15, 4'b1000, 0, 0, 0);
    check("cmp_carry", {31'd0, carry}, 32'd0);
    check("cmp_no_write", pw_cnt * 10 + rw_cnt, 10);
    instr("bl_not_taken", 2'b10, 6'b110000, 4'h0, 4'd0, 4'b0000, 0, 0, 0);
    check("beq_not_taken_pcw", pw_cnt, 1);
    instr("bne_taken", 2'b10, 6'b100000, 4'h1, 4'd0, 4'b0000, 0, 0, 0);
    check("bne_taken_pcw", pw_cnt, 2);
    instr("movi", 2'b00, 6'b111010, 4'he, 4'd3, 4'b0000, 0, 0, 0);
    check("mov_regwrite", rw_cnt, 1);
    instr("orrs_gt_fail", 2'b00, 6'b011001, 4'hc, 4'd4, 4'b0000, 0, 0, 0);
    check("gt_fail_no_write", rw_cnt, 0);
    instr("ands_lt", 2'b00, 6'b000001, 4'hb, 4'd5, 4'b0110, 0, 0, 0);
    check("and_keeps_carry", {31'd0, carry}, 32'd0);
    instr("subs_imm", 2'b00, 6'b100101, 4'he, 4'd6, 4'b0011, 0, 0, 0);
    check("subs_carry", {31'd0, carry}, 32'd1);
    instr("str_sub", 2'b01, 6'b010000, 4'he, 4'd0, 4'b0000, 0, 2, 0);
    check("str_memwrite_cycles", mw_cnt, 3);
    instr("str_never", 2'b01, 6'b011000, 4'hf, 4'd0, 4'b0000, 0, 1, 0);
    check("str_never_memwrite", mw_cnt, 0);
    instr("str_timeout", 2'b01, 6'b011000, 4'he, 4'd0, 4'b0000, 0, 20, 0);
    check("timeout_memwrite_cycles", mw_cnt, 15);
    check("timeout_bus_fault", bf_cnt, 1);
    instr("op11", 2'b11, 6'b000000, 4'he, 4'd0, 4'b0000, 0, 0, 0);
    check("op11_illegal", ill_cnt, 1);
    instr("eor_illegal", 2'b00, 6'b000011, 4'he, 4'd7, 4'b1111, 0, 0, 0);
    check("eor_illegal_pulse", ill_cnt, 1);
    check("eor_flags_kept", {31'd0, carry}, 32'd1);

    instr("str_reset", 2'b01, 6'b011000, 4'he, 4'd0, 4'b0000, 0, 20, 5);
    #2;
    check("memwr_before_reset", {31'd0, mem_write}, 32'd1);
    reset = 1;
    #1;
    check("reset_drops_memwrite", {31'd0, mem_write}, 32'd0);
    check("reset_clears_carry", {31'd0, carry}, 32'd0);
    check("reset_fetch_mux", {28'd0, adr_src, alu_src_a, alu_src_b}, 32'b0110);
    exp_q.delete(); msk_q.delete(); mr_q.delete();
    flags_m = 4'b0000;
    @(posedge clk); #1;
    reset = 0;
    instr("adds_after_reset", 2'b00, 6'b001001, 4'he, 4'd1, 4'b0010, 2, 0, 0);
    check("adds_after_reset_carry", {31'd0, carry}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle successor to the single-cycle controller. The FSM sequences fetch, decode, execute, memory and writeback over several cycles with one shared memory port. A mem_ready handshake lets memory insert wait states, and a bounded timeout catches a hung bus. The block drives the multicycle datapath muxes/enables, holds NZCV flags and latches the condition result per instruction.

Parameters:
HAS_MEM_READY, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1
TIMEOUT_CYCLES, 16, max consecutive wait cycles in one memory state before bus_fault; 0 disables; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
op  input  2  instr[27:26]
funct  input  6  instr[25:20]
cond  input  4  instr[31:28]
rd  input  4  instr[15:12]
alu_flags  input  4  {N,Z,C,V} from ALU, current cycle
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC load enable
ir_write  output  1  instruction register load enable
adr_src  output  1  0 = PC, 1 = ALU result register
mem_write  output  1  memory write strobe
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = Rn, 1 = PC
alu_src_b  output  2  00 = Rm (shifted), 01 = ExtImm, 10 = constant 4
result_src  output  2  00 = ALU reg, 01 = read data, 10 = ALU direct
imm_src  output  2  op passed through
reg_src  output  2  {op==01, op==10}
alu_ctl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
shift  output  1  MOV-with-shift select
carry  output  1  stored C flag
illegal  output  1  one-cycle pulse on undefined op/cmd
bus_fault  output  1  one-cycle pulse on timeout

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Reset (async): state = FETCH, flags = 0000, cond_q = 0, wait counter = 0, all outputs 0 except those combinationally implied by FETCH.
- FETCH: adr_src = 0, alu_src_a = 1, alu_src_b = 10, ADD, result_src = 10. ir_write and pc_write = 1 only when mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: alu_src_a = 1, alu_src_b = 10 (PC+8). Latch cond_q = condition(cond, flags). Next state by op:
  - 00 with funct[5]=0 -> EXECR; with funct[5]=1 -> EXECI
  - 01 -> MEMADR
  - 10 -> BRANCH
  - 11 -> FETCH with illegal pulse
- Condition: EQ..LE per ARM encoding on stored {N,Z,C,V}. AL (1110) = 1. Code 1111 = 0.
- MEMADR: alu_src_b = 01; ADD if funct[3] (U) = 1, else SUB. Next: MEMRD if funct[0] (L) = 1, else MEMWR.
- MEMRD: adr_src = 1. Wait for mem_ready -> MEMWB.
- MEMWB: result_src = 01, reg_write = cond_q. Next FETCH.
- MEMWR: adr_src = 1, mem_write = cond_q, held every cycle until mem_ready. Next FETCH.
- EXECR/EXECI: alu_src_a = 0, alu_src_b = 00 or 01. cmd = funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR
  - 1010 CMP: SUB, no_write
  - 1101 MOV: shift = 1
  - other cmd: illegal pulse, go to FETCH, no flag or register write
  - Otherwise next ALUWB.
- Flag update at the EXECR/EXECI clock edge when cond_q & funct[0]: N,Z always; C,V only for ADD/SUB/CMP.
- ALUWB: result_src = 00.
  - rd != 15: reg_write = cond_q & ~no_write
  - rd == 15 and not no_write: pc_write = cond_q, reg_write = 0
  - Next FETCH.
- BRANCH: alu_src_a = 0, alu_src_b = 01, ADD, result_src = 10, pc_write = cond_q. L bit ignored (BL executes as B). Next FETCH.
- Wait counter counts cycles in FETCH/MEMRD/MEMWR with mem_ready = 0 and clears on state change. On reaching TIMEOUT_CYCLES: bus_fault pulse, go to FETCH, no strobes that cycle.
- A condition that fails still traverses all states; only write enables are suppressed.
- Reset mid-access drops all strobes immediately.

Test Plan:
- Reset mid-MEMWR with mem_ready = 0 -> mem_write falls the same cycle; state = FETCH, carry = 0.
- ADDS R1 (op 00, funct 001001, cond 1110), alu_flags = 0110, mem_ready = 1 -> 4 cycles FETCH/DECODE/EXECR/ALUWB; reg_write in cycle 4 only; carry = 1 afterwards.
- LDR (op 01, funct 011001) with mem_ready low for 3 cycles in MEMRD -> MEMWB 4 cycles after MEMRD entry; reg_write = 1 exactly once.
- BEQ with stored Z = 0 -> BRANCH with pc_write = 0. Same with Z = 1 -> pc_write = 1.
- MEMWR with mem_ready stuck 0, TIMEOUT_CYCLES = 16 -> bus_fault pulses in the 16th wait cycle; next state FETCH.
- op = 11 -> illegal pulse in DECODE, next FETCH. CMP with rd = 15 -> no pc_write or reg_write, flags updated.
